// File: rtl/pe_pkg.sv
// pe_pkg: shared state encoding, default widths and queue-entry helpers for the PE controllers
package pe_pkg;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_LAYER_W = 4;
    localparam int DEF_QUEUE_W = DEF_ADDR_W + DEF_DATA_W;

    typedef enum logic [2:0] {IDLE, START, FETCH, PUSH, DRAIN, NEXT} state_t;

    function automatic logic [DEF_QUEUE_W-1:0] pack_entry(input logic [DEF_ADDR_W-1:0] idx,
                                                          input logic [DEF_DATA_W-1:0] val);
        return {idx, val};
    endfunction

    function automatic logic [DEF_ADDR_W-1:0] entry_idx(input logic [DEF_QUEUE_W-1:0] e);
        return e[DEF_QUEUE_W-1 -: DEF_ADDR_W];
    endfunction

    function automatic logic [DEF_DATA_W-1:0] entry_val(input logic [DEF_QUEUE_W-1:0] e);
        return e[DEF_DATA_W-1:0];
    endfunction
endpackage

// File: rtl/pe_idle_sync.sv
// pe_idle_sync: asserts ready once all PEs have been idle for CYCLES consecutive enabled cycles
module pe_idle_sync #(
    parameter int N      = 64,
    parameter int CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] idle,
    output logic         ready
);
    localparam int CW = $clog2(CYCLES) + 1;

    logic [CW-1:0] cnt;
    logic          all_idle;

    assign all_idle = &idle;
    assign ready    = en && all_idle && (cnt == CW'(CYCLES - 1));

    // A single idle cycle can be a pop-to-idle glitch, so the run must be unbroken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= (en && all_idle) ? (ready ? cnt : cnt + 1'b1) : '0;
    end
endmodule

// File: rtl/pe_layer_sequencer.sv
// pe_layer_sequencer: per-layer start, activation broadcast and drain sequencing across the PE array.
// Build option SEQ_SKIP_ZERO_EN: zero-valued activations are consumed without being pushed.
module pe_layer_sequencer
    import pe_pkg::*;
#(
    parameter  int NUM_PE  = 64,
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int ADDR_W  = DEF_ADDR_W,
    parameter  int LAYER_W = DEF_LAYER_W,
    localparam int QUEUE_W = ADDR_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LAYER_W-1:0] layer_no,
    input  logic [ADDR_W-1:0]  in_act_no,
    output logic               src_rd_en,
    output logic [ADDR_W-1:0]  src_rd_addr,
    input  logic [DATA_W-1:0]  src_rd_data,
    input  logic [NUM_PE-1:0]  pe_queue_full,
    input  logic [NUM_PE-1:0]  pe_idle,
    output logic               push_act,
    output logic [QUEUE_W-1:0] act_data,
    output logic               pe_start_calc,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               busy,
    output logic               done
);
    state_t             state, state_n;
    logic [ADDR_W-1:0]  rd_ptr, acts;
    logic [LAYER_W-1:0] layers;
    logic [DATA_W-1:0]  hold, data;
    logic               fresh, any_full, skip, advance, last_act, last_layer, drained;

    assign any_full = |pe_queue_full;
    // Read data is only valid on the first PUSH cycle; stalled cycles reuse the held copy
    assign data     = fresh ? src_rd_data : hold;
`ifdef SEQ_SKIP_ZERO_EN
    assign skip     = data == '0;
`else
    assign skip     = 1'b0;
`endif
    assign advance     = skip || !any_full;
    assign last_act    = rd_ptr == acts - ADDR_W'(1);
    assign last_layer  = layer_idx == layers - LAYER_W'(1);
    assign busy        = state != IDLE;
    assign src_rd_addr = src_rd_en ? rd_ptr : '0;
    assign act_data    = push_act ? {rd_ptr, data} : '0;

    pe_idle_sync #(.N(NUM_PE), .CYCLES(2)) u_idle_sync (
        .clk   (clk),
        .rst   (rst),
        .en    (state == DRAIN),
        .idle  (pe_idle),
        .ready (drained)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            layer_idx <= '0;
            acts      <= '0;
            layers    <= '0;
            hold      <= '0;
            fresh     <= 1'b0;
        end else begin
            state <= state_n;
            fresh <= state == FETCH;
            if (fresh) hold <= src_rd_data;
            if (state == IDLE && start) begin
                layers    <= (layer_no == '0) ? LAYER_W'(1) : layer_no;
                acts      <= in_act_no;
                layer_idx <= '0;
                rd_ptr    <= '0;
            end
            if (state == START) rd_ptr <= '0;
            if (state == PUSH && advance && !last_act) rd_ptr <= rd_ptr + 1'b1;
            if (state == NEXT) layer_idx <= last_layer ? '0 : layer_idx + 1'b1;
        end
    end

    always_comb begin
        state_n       = state;
        pe_start_calc = 1'b0;
        src_rd_en     = 1'b0;
        push_act      = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE:  state_n = start ? START : IDLE;
            START: begin
                pe_start_calc = 1'b1;
                state_n       = (acts == '0) ? DRAIN : FETCH;
            end
            FETCH: begin
                src_rd_en = 1'b1;
                state_n   = PUSH;
            end
            PUSH: begin
                push_act = advance && !skip;
                state_n  = !advance ? PUSH : last_act ? DRAIN : FETCH;
            end
            DRAIN: state_n = drained ? NEXT : DRAIN;
            NEXT: begin
                done    = last_layer;
                state_n = last_layer ? IDLE : START;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pe_layer_sequencer.sv
// tb_pe_layer_sequencer: directed and randomized runs checked against a queue-based broadcast model
module tb_pe_layer_sequencer;
    localparam int NUM_PE  = 64;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 12;
    localparam int LAYER_W = 4;
    localparam int QUEUE_W = ADDR_W + DATA_W;
`ifdef SEQ_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [LAYER_W-1:0] layer_no = '0;
    logic [ADDR_W-1:0]  in_act_no = '0;
    logic               src_rd_en;
    logic [ADDR_W-1:0]  src_rd_addr;
    logic [DATA_W-1:0]  src_rd_data;
    logic [NUM_PE-1:0]  pe_queue_full = '0;
    logic [NUM_PE-1:0]  pe_idle = '1;
    logic               push_act;
    logic [QUEUE_W-1:0] act_data;
    logic               pe_start_calc;
    logic [LAYER_W-1:0] layer_idx;
    logic               busy;
    logic               done;

    pe_layer_sequencer #(
        .NUM_PE  (NUM_PE),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .LAYER_W (LAYER_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .layer_no      (layer_no),
        .in_act_no     (in_act_no),
        .src_rd_en     (src_rd_en),
        .src_rd_addr   (src_rd_addr),
        .src_rd_data   (src_rd_data),
        .pe_queue_full (pe_queue_full),
        .pe_idle       (pe_idle),
        .push_act      (push_act),
        .act_data      (act_data),
        .pe_start_calc (pe_start_calc),
        .layer_idx     (layer_idx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Source buffer: one-cycle read latency, garbage on cycles without a read
    logic [DATA_W-1:0] mem [0:63];
    always @(posedge clk) src_rd_data <= src_rd_en ? mem[src_rd_addr[5:0]] : DATA_W'($urandom);

    int errors = 0;
    int checks = 0;
    int start_cnt, done_cnt, rd_cnt, push_cnt, cur_acts, cur_layers;
    logic [QUEUE_W-1:0] exp_q[$];
    logic [QUEUE_W:0]   exp_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pe_start_calc) begin
                chk("start_layer", 64'(layer_idx), 64'(start_cnt));
                start_cnt++;
            end
            if (src_rd_en) begin
                chk("rd_addr", 64'(src_rd_addr), 64'(cur_acts == 0 ? 0 : rd_cnt % cur_acts));
                rd_cnt++;
            end
            if (push_act) begin
                push_cnt++;
                chk("push_not_full", 64'(|pe_queue_full), 64'd0);
                exp_e = (exp_q.size() > 0) ? {1'b1, exp_q.pop_front()} : '0;
                chk("push_entry", 64'({1'b1, act_data}), 64'(exp_e));
            end
            if (done) begin
                chk("done_layer", 64'(layer_idx), 64'(cur_layers - 1));
                done_cnt++;
            end
        end
    end

    task automatic start_run(input int layers, input int acts);
        start_cnt  = 0;
        done_cnt   = 0;
        rd_cnt     = 0;
        push_cnt   = 0;
        exp_q.delete();
        cur_layers = (layers == 0) ? 1 : layers;
        cur_acts   = acts;
        for (int l = 0; l < cur_layers; l++)
            for (int i = 0; i < acts; i++)
                if (!(SKIP && mem[i] == '0)) exp_q.push_back({ADDR_W'(i), mem[i]});
        layer_no  = LAYER_W'(layers);
        in_act_no = ADDR_W'(acts);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        layer_no  = LAYER_W'($urandom);
        in_act_no = ADDR_W'($urandom);
        chk("busy_run", 64'(busy), 64'd1);
        chk("start_pulse", 64'(pe_start_calc), 64'd1);
    endtask

    task automatic finish_run(input bit rnd);
        int n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
            if (rnd) begin
                pe_queue_full = ($urandom_range(0, 2) == 0) ? (64'd1 << $urandom_range(0, 63)) : '0;
                pe_idle       = ($urandom_range(0, 2) == 0) ? ~(64'd1 << $urandom_range(0, 63)) : '1;
                start         = ($urandom_range(0, 7) == 0);
            end
        end
        start         = 1'b0;
        pe_queue_full = '0;
        pe_idle       = '1;
        chk("done_seen", 64'(done_cnt), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("busy_after", 64'(busy), 64'd0);
        chk("layer_idx_after", 64'(layer_idx), 64'd0);
        chk("starts", 64'(start_cnt), 64'(cur_layers));
        chk("reads", 64'(rd_cnt), 64'(cur_layers * cur_acts));
        chk("pushes_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_push"}, 64'(push_act), 64'd0);
        chk({tag, "_data"}, 64'(act_data), 64'd0);
        chk({tag, "_rd_en"}, 64'(src_rd_en), 64'd0);
        chk({tag, "_rd_addr"}, 64'(src_rd_addr), 64'd0);
        chk({tag, "_start"}, 64'(pe_start_calc), 64'd0);
        chk({tag, "_layer"}, 64'(layer_idx), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'($urandom_range(1, 65535));
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic two-layer run, three activations, no backpressure
        start_run(2, 3);
        finish_run(0);

        // Stall on the second entry: no push, no re-read, value survives
        mem[1] = 16'hBEEF;
        start_run(1, 3);
        n = 0;
        while (rd_cnt < 2 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        pe_queue_full[17] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_push", 64'(push_act), 64'd0);
            chk("stall_rd", 64'(src_rd_en), 64'd0);
            @(posedge clk);
            #1;
        end
        pe_queue_full = '0;
        @(negedge clk);
        chk("stall_release", 64'(push_act), 64'd1);
        chk("stall_entry", 64'(act_data), 64'({ADDR_W'(1), 16'hBEEF}));
        chk("stall_reads", 64'(rd_cnt), 64'd2);
        finish_run(0);

        // Empty layer and zero layer count
        start_run(1, 0);
        finish_run(0);
        start_run(0, 2);
        finish_run(0);

        // Drain race: a lone all-idle cycle must not advance
        pe_idle = ~(64'd1 << 5);
        start_run(1, 1);
        repeat (6) @(posedge clk);
        #1;
        pe_idle = '1;
        @(posedge clk);
        #1;
        pe_idle = ~(64'd1 << 40);
        repeat (4) @(negedge clk);
        chk("race_no_done", 64'(done_cnt), 64'd0);
        chk("race_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        pe_idle = '1;
        @(negedge clk);
        chk("drain_t1", 64'(done), 64'd0);
        @(negedge clk);
        chk("drain_t2", 64'(done), 64'd0);
        @(negedge clk);
        chk("drain_t3", 64'(done), 64'd1);
        finish_run(0);

        // Reset while pushing in layer 1 of 3
        start_run(3, 4);
        n = 0;
        while (!(start_cnt == 2 && rd_cnt == 5) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        start_run(3, 4);
        finish_run(0);

        // Zero-valued activation handling
        mem[0] = 16'd5;
        mem[1] = 16'd0;
        mem[2] = 16'd7;
        start_run(1, 3);
        finish_run(0);
        chk("zero_pushes", 64'(push_cnt), SKIP ? 64'd2 : 64'd3);

        // Randomized runs with random stalls, idle glitches and ignored start pulses
        repeat (8) begin
            for (int i = 0; i < 8; i++)
                mem[i] = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
            start_run($urandom_range(0, 4), $urandom_range(0, 7));
            finish_run(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/pe_layer_sequencer.md
Name: pe_layer_sequencer

Overview:
- Top-level controller that sequences multi-layer computation across the PE array.
- Per layer:
  - pulses pe_start_calc to every PE;
  - reads the layer's input activations from the source activation buffer;
  - broadcasts each {index, value} pair into all PE activation queues, with backpressure;
  - waits until every PE has drained;
  - advances the layer index.
- Sits between the global activation buffer and the NUM_PE PE instances.
- Owns the global layer index that the buffer uses for bank selection.

Parameters:
- NUM_PE, 64, number of PEs fed by the broadcast.
- DATA_W, 16, activation value width.
- ADDR_W, 12, input activation index width.
- LAYER_W, 4, layer counter width.
- QUEUE_W, ADDR_W+DATA_W, queue entry width. Derived; do not override.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  start a full network run (single-cycle pulse)
- layer_no  in  LAYER_W  total layers in the run
- in_act_no  in  ADDR_W  input activations per layer
- src_rd_en  out  1  source buffer read strobe
- src_rd_addr  out  ADDR_W  source buffer read address
- src_rd_data  in  DATA_W  source read data, valid exactly 1 cycle after src_rd_en
- pe_queue_full  in  NUM_PE  per-PE activation queue full
- pe_idle  in  NUM_PE  per-PE idle (queue empty and no compute in flight)
- push_act  out  1  broadcast push into all PE queues
- act_data  out  QUEUE_W  pushed entry, {index[ADDR_W-1:0], value[DATA_W-1:0]}
- pe_start_calc  out  1  per-layer start pulse to all PEs
- layer_idx  out  LAYER_W  current layer index
- busy  out  1  high whenever state is not IDLE
- done  out  1  single-cycle pulse when the final layer completes

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All state, counters and registered outputs clear to 0.
  - State goes to IDLE; all outputs are 0.
  - rst asserted mid-run aborts the run immediately. No done pulse is produced; layer_idx returns to 0.
- Latched values:
  - layer_no and in_act_no are latched on accepted start.
  - latched layer_no = 0 is treated as 1.
  - Inputs changing mid-run are ignored.
- IDLE:
  - start → START; layer_idx = 0; rd_ptr = 0.
  - start in any other state is ignored.
- START:
  - pe_start_calc = 1 for exactly this cycle; rd_ptr = 0.
  - Next state is FETCH, or DRAIN if latched in_act_no = 0.
- FETCH:
  - src_rd_en = 1 and src_rd_addr = rd_ptr for one cycle → PUSH.
- PUSH:
  - Read data is captured into a hold register on entry.
  - any_full = |pe_queue_full.
  - If any_full = 0: push_act = 1 and act_data = {rd_ptr, data}.
    - If rd_ptr == in_act_no-1 → DRAIN; otherwise rd_ptr++ → FETCH.
  - If any_full = 1: stay in PUSH with push_act = 0; the hold register keeps the data (no re-read).
  - Throughput: 1 entry per 2 cycles unstalled.
- DRAIN:
  - Wait until &pe_idle is 1 for 2 consecutive cycles (filters the pop-to-idle race) → NEXT.
- NEXT:
  - If layer_idx == layer_no-1: done = 1 for this cycle; layer_idx = 0 → IDLE.
  - Otherwise layer_idx++ → START.
- push_act, src_rd_en, pe_start_calc and done are combinational from state and counters. Each is never asserted outside its state.
- Comparisons are at full width with no wrap. in_act_no max 2^ADDR_W-1.

Optional Feature:
- Macro SEQ_SKIP_ZERO_EN.
- Defined: in PUSH, a zero value is not pushed (push_act = 0). rd_ptr still advances and the state transitions as if pushed, independent of any_full.
- Undefined: every activation is pushed, including zeros.

Decomposition:
- Shared package pe_pkg:
  - state enum (IDLE, START, FETCH, PUSH, DRAIN, NEXT);
  - DATA_W, ADDR_W and LAYER_W defaults;
  - queue-entry packing helpers.
- One natural sub-module: pe_idle_sync. It is the 2-cycle all-idle qualifier (AND-reduce plus a consecutive counter) and is reused by other controllers.

Test Plan:
- layer_no=2, in_act_no=3, queues never full, pe_idle=all 1 → pe_start_calc pulses twice; act_data indexes 0,1,2 per layer; done 1 cycle after second DRAIN; busy low after.
- Stall: hold pe_queue_full[17]=1 for 5 cycles during the second PUSH → push_act=0 for those cycles, entry index 1 pushed once with the unchanged value; src_rd_en not reasserted.
- in_act_no=0, layer_no=1 → START→DRAIN→NEXT; no src_rd_en, no push; done pulses.
- Drain race: pe_idle all-1 for a single cycle, then one bit low → no advance; advance only after 2 consecutive all-1 cycles.
- Assert rst during PUSH of layer 1 of 3 → all outputs 0 the same cycle, no done; a new start re-runs from layer_idx=0.
- SEQ_SKIP_ZERO_EN defined, values {5,0,7} → exactly two pushes, indexes 0 and 2; undefined → three pushes.
